// File: rtl/audio_tx_pkg.sv
// Shared types and constants for the audio serial transmitter.
package audio_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned UNDERRUN_CNT_W = 8;

endpackage

// File: rtl/audio_tx_bclk_gen.sv
// Bit-clock generator: divides clk by 2*CLKDIV and flags the cycle before each bclk edge.
module audio_tx_bclk_gen #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run_en_i,
  output logic bclk_o,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             tick_c;

  assign tick_c      = run_en_i && (div_q == DIV_W'(CLKDIV - 1));
  assign rise_tick_c = tick_c && !bclk_q;
  assign fall_tick_c = tick_c && bclk_q;
  assign bclk_o      = bclk_q;

  // Divider and bclk are held at zero while not running.
  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!run_en_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (tick_c) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/audio_serial_tx.sv
// I2S-style stereo serializer with a one-pair holding buffer.
// Optional macro AUDIO_SERIAL_TX_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_serial_tx
  import audio_tx_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic             valid,
  output logic             ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
`ifdef AUDIO_SERIAL_TX_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

  localparam int unsigned FRAME_W = 2 * WIDTH;
  localparam int unsigned SLOT_W  = $clog2(FRAME_W);

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               lrclk_q, lrclk_d;
  logic               underrun_q, underrun_d;
  logic               run_en_c;
  logic               rise_tick_c;
  logic               fall_tick_c;

  assign run_en_c = (state_q == RUN);

  audio_tx_bclk_gen #(
    .CLKDIV(CLKDIV)
  ) u_bclk_gen (
    .clk        (clk),
    .reset      (reset),
    .run_en_i   (run_en_c),
    .bclk_o     (bclk),
    .rise_tick_c(rise_tick_c),
    .fall_tick_c(fall_tick_c)
  );

  assign ready    = ~buf_full_q;
  assign sdata    = shift_q[FRAME_W-1];
  assign lrclk    = lrclk_q;
  assign underrun = underrun_q;

  // FSM, slot sequencing, frame reload and buffer fill.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = RUN;
          slot_d  = '0;
          shift_d = {left_in, right_in};
        end
      end
      RUN: begin
        if (fall_tick_c) begin
          if (slot_q == SLOT_W'(FRAME_W - 1)) begin
            slot_d = '0;
            if (buf_full_q) begin
              shift_d    = buf_q;
              buf_full_d = 1'b0;
            end else begin
              shift_d    = '0;
              underrun_d = 1'b1;
            end
          end else begin
            slot_d  = slot_q + SLOT_W'(1);
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          end
        end
        // The reload above sees the old buffer; a same-cycle accept refills it afterwards.
        if (valid && !buf_full_q) begin
          buf_d      = {left_in, right_in};
          buf_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    lrclk_d = (slot_d >= SLOT_W'(WIDTH - 1)) && (slot_d <= SLOT_W'(FRAME_W - 2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
    end
  end

  // A rising tick can only be issued while bclk is low.
  assert property (@(posedge clk) disable iff (reset) rise_tick_c |-> !bclk);

`ifdef AUDIO_SERIAL_TX_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] cnt_q;

  // Counts alongside the underrun pulse, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (underrun_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + UNDERRUN_CNT_W'(1);
    end
  end

  assign underrun_count = cnt_q;
`endif

endmodule
